// File: rtl/matvec_param.sv
// Parameterised N x N signed matrix-vector multiplier with a single MAC.
// The matrix is retained across transactions; outputs saturate to OW bits with optional ReLU.
module matvec_param #(
  parameter int N  = 8,
  parameter int W  = 14,
  parameter int OW = 28
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic [W-1:0]  input_data,
  input  logic          new_matrix,
  input  logic          relu_en,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [OW-1:0] output_data,
  output logic          output_sat
);

  localparam int AW = 2*W + $clog2(N);
  localparam int MA = $clog2(N*N);
  localparam int XW = $clog2(N);
  localparam int JW = $clog2(N+1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_V = 3'd2,
    MAC    = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t state;

  logic signed [W-1:0]    m_mem [N*N];
  logic signed [W-1:0]    x_mem [N];
  logic [MA-1:0]          cnt;
  logic [MA-1:0]          maddr;
  logic [JW-1:0]          j;
  logic [XW-1:0]          k;
  logic signed [AW-1:0]   acc;
  logic                   relu;
  logic                   matrix_loaded;

  logic                   in_fire;
  logic                   load_new;
  logic                   m_we;
  logic                   x_we;
  logic [MA-1:0]          m_waddr;
  logic [XW-1:0]          x_waddr;
  logic signed [2*W-1:0]  prod;
  logic [OW-1:0]          clamp_data;
  logic [OW-1:0]          res_data;
  logic                   res_sat;

  // Input handshake decode and storage write enables
  always_comb begin
    in_fire  = input_valid && input_ready;
    load_new = new_matrix || !matrix_loaded;
    m_we     = 1'b0;
    x_we     = 1'b0;
    m_waddr  = '0;
    x_waddr  = '0;
    case (state)
      IDLE: begin
        m_we = in_fire && load_new;
        x_we = in_fire && !load_new;
      end
      LOAD_M: begin
        m_we    = in_fire;
        m_waddr = cnt;
      end
      LOAD_V: begin
        x_we    = in_fire;
        x_waddr = cnt[XW-1:0];
      end
      default: begin
        m_we = 1'b0;
        x_we = 1'b0;
      end
    endcase
  end

  // Product, clamp and ReLU of the current row result
  always_comb begin
    prod       = m_mem[maddr] * x_mem[j[XW-1:0]];
    res_sat    = 1'b0;
    clamp_data = acc[OW-1:0];
    if (acc > SAT_MAX) begin
      clamp_data = SAT_MAX[OW-1:0];
      res_sat    = 1'b1;
    end else if (acc < SAT_MIN) begin
      clamp_data = SAT_MIN[OW-1:0];
      res_sat    = 1'b1;
    end else begin
      clamp_data = acc[OW-1:0];
      res_sat    = 1'b0;
    end
    res_data = (relu && acc[AW-1]) ? '0 : clamp_data;
  end

  // Matrix and vector storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (m_we) m_mem[m_waddr] <= input_data;
    if (x_we) x_mem[x_waddr] <= input_data;
  end

  // Control FSM with registered handshake and output signals
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      input_ready   <= 1'b0;
      output_valid  <= 1'b0;
      output_data   <= '0;
      output_sat    <= 1'b0;
      cnt           <= '0;
      maddr         <= '0;
      j             <= '0;
      k             <= '0;
      acc           <= '0;
      relu          <= 1'b0;
      matrix_loaded <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          input_ready <= 1'b1;
          if (in_fire) begin
            relu  <= relu_en;
            cnt   <= MA'(1);
            state <= load_new ? LOAD_M : LOAD_V;
          end
        end
        LOAD_M: begin
          if (in_fire) begin
            if (cnt == MA'(N*N-1)) begin
              matrix_loaded <= 1'b1;
              cnt           <= '0;
              state         <= LOAD_V;
            end else begin
              cnt <= cnt + MA'(1);
            end
          end
        end
        LOAD_V: begin
          if (in_fire) begin
            if (cnt == MA'(N-1)) begin
              input_ready <= 1'b0;
              cnt         <= '0;
              maddr       <= '0;
              j           <= '0;
              k           <= '0;
              acc         <= '0;
              state       <= MAC;
            end else begin
              cnt <= cnt + MA'(1);
            end
          end
        end
        MAC: begin
          // One extra cycle after the N products to register the clamped result
          if (j == JW'(N)) begin
            output_valid <= 1'b1;
            output_data  <= res_data;
            output_sat   <= res_sat;
            state        <= OUT;
          end else begin
            acc   <= acc + {{(AW-2*W){prod[2*W-1]}}, prod};
            j     <= j + JW'(1);
            maddr <= maddr + MA'(1);
          end
        end
        OUT: begin
          if (output_ready) begin
            output_valid <= 1'b0;
            if (k == XW'(N-1)) begin
              input_ready <= 1'b1;
              state       <= IDLE;
            end else begin
              k     <= k + XW'(1);
              j     <= '0;
              acc   <= '0;
              state <= MAC;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
